// File: rtl/matrix_gen_3x3_8bit.sv
// 3x3 neighbourhood generator for an 8-bit pixel stream fed by an external two-line buffer.
// Produces a zero-padded window two cycles after each pixel strobe, with matching delayed syncs.
module matrix_gen_3x3_8bit (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] per_img_y,
   output logic       line_href,
   output logic       line_clken,
   output logic [7:0] line_shiftin,
   input  logic [7:0] taps0x,
   input  logic [7:0] taps1x,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic [7:0] m11,
   output logic [7:0] m12,
   output logic [7:0] m13,
   output logic [7:0] m21,
   output logic [7:0] m22,
   output logic [7:0] m23,
   output logic [7:0] m31,
   output logic [7:0] m32,
   output logic [7:0] m33,
   output logic       matrix_interior
);

   localparam logic [10:0] COL_MAX = 11'd2047;

   logic [7:0]  y_d1;
   logic        clken_d1;
   logic        href_d1;
   logic        vsync_d1;
   logic [10:0] col_cnt;
   logic [1:0]  line_cnt;

   logic        vsync_rise;
   logic        href_fall;
   logic        left_edge;
   logic [7:0]  top_new;
   logic [7:0]  mid_new;

   assign line_href    = per_frame_href;
   assign line_clken   = per_frame_clken;
   assign line_shiftin = per_img_y;

   assign vsync_rise = per_frame_vsync & ~vsync_d1;
   assign href_fall  = href_d1 & ~per_frame_href;
   assign left_edge  = (col_cnt == 11'd0);

   // Rows above the frame top are masked to zero; line_cnt is the pre-increment value.
   always_comb begin
      top_new = 8'h00;
      mid_new = 8'h00;
      if (line_cnt == 2'd2) top_new = taps1x;
      if (line_cnt != 2'd0) mid_new = taps0x;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         y_d1             <= 8'h00;
         clken_d1         <= 1'b0;
         href_d1          <= 1'b0;
         vsync_d1         <= 1'b0;
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_clken <= 1'b0;
         col_cnt          <= 11'd0;
         line_cnt         <= 2'd0;
         m11              <= 8'h00;
         m12              <= 8'h00;
         m13              <= 8'h00;
         m21              <= 8'h00;
         m22              <= 8'h00;
         m23              <= 8'h00;
         m31              <= 8'h00;
         m32              <= 8'h00;
         m33              <= 8'h00;
         matrix_interior  <= 1'b0;
      end else begin
         y_d1             <= per_img_y;
         clken_d1         <= per_frame_clken;
         href_d1          <= per_frame_href;
         vsync_d1         <= per_frame_vsync;
         post_frame_vsync <= vsync_d1;
         post_frame_href  <= href_d1;
         post_frame_clken <= clken_d1;

         if (!href_d1) col_cnt <= 11'd0;
         else if (clken_d1 && (col_cnt != COL_MAX)) col_cnt <= col_cnt + 11'd1;

         // A frame start overrides a coincident end-of-line increment.
         if (vsync_rise) line_cnt <= 2'd0;
         else if (href_fall && (line_cnt != 2'd2)) line_cnt <= line_cnt + 2'd1;

         if (clken_d1) begin
            m11 <= left_edge ? 8'h00 : m12;
            m12 <= left_edge ? 8'h00 : m13;
            m13 <= top_new;
            m21 <= left_edge ? 8'h00 : m22;
            m22 <= left_edge ? 8'h00 : m23;
            m23 <= mid_new;
            m31 <= left_edge ? 8'h00 : m32;
            m32 <= left_edge ? 8'h00 : m33;
            m33 <= y_d1;
         end

         matrix_interior <= clken_d1 && (line_cnt == 2'd2) && (col_cnt >= 11'd2);
      end
   end

endmodule
